// File: rtl/hmac_pkg.sv
// Shared types and constants for the HMAC message padder.
// Build option: define HMAC_HW_PAD_EN to enable hardware SHA-512 padding and the PAD2 block.
package hmac_pkg;
    localparam int         HMAC_BLOCK_W = 1024;
    localparam int         HMAC_WORDS   = 32;
    localparam int         HMAC_LEN_W   = 128;
    localparam logic [7:0] PAD_BYTE     = 8'h80;

`ifdef HMAC_HW_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, PAD2} hmac_state_e;

    // Oversized byte counts on the last word saturate at a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] b);
        return (b > 3'd4) ? 3'd4 : b;
    endfunction

    // Keeps the leading nb bytes of a big-endian word (nb in 0..4).
    function automatic logic [31:0] keep_mask(input logic [2:0] nb);
        return ~(32'hFFFF_FFFF >> {nb, 3'b000});
    endfunction
endpackage

// File: rtl/hmac_pad_gen.sv
// Combinational padder: places the 0x80 marker and the 128-bit bit length into a block,
// and flags when the length does not fit and a further block is needed.
module hmac_pad_gen
    import hmac_pkg::*;
(
    input  logic [HMAC_BLOCK_W-1:0] blk_i,
    input  logic [7:0]              pos_i,
    input  logic                    mark_i,
    input  logic [31:0]             byte_cnt_i,
    output logic [HMAC_BLOCK_W-1:0] blk_o,
    output logic                    extra_o
);
    localparam int LEN_POS = (HMAC_BLOCK_W - HMAC_LEN_W) / 8;

    logic [HMAC_LEN_W-1:0] len_bits;
    logic [9:0]            mark_hi;

    always_comb begin
        // The inner hash has already absorbed the 1024-bit ipad block.
        len_bits = (HMAC_LEN_W'(byte_cnt_i) << 3) + HMAC_LEN_W'(HMAC_BLOCK_W);
        mark_hi  = 10'(HMAC_BLOCK_W - 1) - {pos_i[6:0], 3'b000};
        extra_o  = (pos_i > 8'(LEN_POS - 1));
        blk_o    = blk_i;
        if (mark_i && !pos_i[7]) begin
            blk_o[mark_hi -: 8] = PAD_BYTE;
        end
        if (!extra_o) begin
            blk_o[HMAC_LEN_W-1:0] = len_bits;
        end
    end
endmodule

// File: rtl/hmac_msg_padder.sv
// Collects 32-bit message words into 1024-bit blocks and hands them to the hash core.
// Build option: HMAC_HW_PAD_EN enables hardware padding (see hmac_pkg).
module hmac_msg_padder
    import hmac_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    zeroize,
    input  logic                    start,
    input  logic                    msg_valid,
    input  logic [31:0]             msg_data,
    input  logic                    msg_last,
    input  logic [2:0]              msg_bytes,
    output logic                    msg_ready,
    output logic                    core_init,
    output logic                    core_next,
    output logic [HMAC_BLOCK_W-1:0] core_block,
    input  logic                    core_ready,
    output logic                    busy,
    output logic                    err
);
    hmac_state_e             state_q, state_d;
    logic [HMAC_BLOCK_W-1:0] buf_q, buf_d, buf_w, pad_src, pad_blk;
    logic [4:0]              idx_q, idx_d;
    logic [31:0]             cnt_q, cnt_d, pad_cnt, wdata;
    logic                    first_q, first_d, extra_q, extra_d, last_blk_q, last_blk_d;
    logic                    placed_q, placed_d, skip_q, skip_d, err_q, err_d;
    logic [2:0]              nb;
    logic [9:0]              word_hi;
    logic [32:0]             sum;
    logic [7:0]              pad_pos;
    logic                    pad_mark, pad_extra, in_pad2;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch can form.
    always_comb begin
        nb      = msg_last ? clamp_bytes(msg_bytes) : 3'd4;
        wdata   = (PAD_EN && msg_last) ? (msg_data & keep_mask(nb)) : msg_data;
        word_hi = 10'(HMAC_BLOCK_W - 1) - {idx_q, 5'b00000};
        buf_w   = buf_q;
        buf_w[word_hi -: 32] = wdata;
        sum     = {1'b0, cnt_q} + {30'd0, nb};
        in_pad2  = (state_q == PAD2);
        pad_src  = in_pad2 ? '0 : buf_w;
        pad_pos  = in_pad2 ? 8'd0 : ({1'b0, idx_q, 2'b00} + {5'd0, nb});
        pad_mark = in_pad2 ? !placed_q : 1'b1;
        pad_cnt  = in_pad2 ? cnt_q : sum[31:0];
    end

    hmac_pad_gen u_pad_gen (
        .blk_i      (pad_src),
        .pos_i      (pad_pos),
        .mark_i     (pad_mark),
        .byte_cnt_i (pad_cnt),
        .blk_o      (pad_blk),
        .extra_o    (pad_extra)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        extra_d    = extra_q;
        last_blk_d = last_blk_q;
        placed_d   = placed_q;
        skip_d     = skip_q;
        err_d      = err_q;
        core_init  = 1'b0;
        core_next  = 1'b0;
        msg_ready  = (state_q == FILL) && !zeroize;

        unique case (state_q)
            IDLE: if (start) begin
                state_d    = FILL;
                buf_d      = '0;
                idx_d      = '0;
                cnt_d      = '0;
                first_d    = 1'b1;
                extra_d    = 1'b0;
                last_blk_d = 1'b0;
                placed_d   = 1'b0;
                err_d      = 1'b0;
            end
            FILL: if (msg_valid) begin
                buf_d = buf_w;
                cnt_d = sum[31:0];
                idx_d = idx_q + 5'd1;
                if (PAD_EN && sum[32]) err_d = 1'b1;
                if (msg_last) begin
                    state_d    = ISSUE;
                    last_blk_d = 1'b1;
                    if (PAD_EN) begin
                        buf_d      = pad_blk;
                        extra_d    = pad_extra;
                        last_blk_d = !pad_extra;
                        placed_d   = !pad_pos[7];
                    end
                end else if (idx_q == 5'(HMAC_WORDS - 1)) begin
                    state_d    = ISSUE;
                    last_blk_d = 1'b0;
                    extra_d    = 1'b0;
                end
            end
            ISSUE: if (core_ready) begin
                core_init = first_q;
                core_next = !first_q;
                first_d   = 1'b0;
                skip_d    = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                // The core's ready is stale in the cycle right after the pulse.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (core_ready) begin
                    if (last_blk_q) begin
                        state_d = IDLE;
                    end else if (extra_q) begin
                        state_d = PAD2;
                    end else begin
                        state_d = FILL;
                        buf_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            PAD2: begin
                buf_d      = pad_blk;
                extra_d    = 1'b0;
                last_blk_d = 1'b1;
                state_d    = ISSUE;
            end
            default: state_d = IDLE;
        endcase

        if (zeroize) begin
            state_d    = IDLE;
            buf_d      = '0;
            idx_d      = '0;
            cnt_d      = '0;
            first_d    = 1'b0;
            extra_d    = 1'b0;
            last_blk_d = 1'b0;
            placed_d   = 1'b0;
            skip_d     = 1'b0;
            err_d      = 1'b0;
            core_init  = 1'b0;
            core_next  = 1'b0;
        end
    end

    // NOTE: the block buffer holds message data, so it is reset like any other flop rather than left as an unreset RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            extra_q    <= 1'b0;
            last_blk_q <= 1'b0;
            placed_q   <= 1'b0;
            skip_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            extra_q    <= extra_d;
            last_blk_q <= last_blk_d;
            placed_q   <= placed_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
        end
    end

    assign core_block = buf_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
endmodule

// File: tb/tb_hmac_msg_padder.sv
// Randomized self-checking bench for hmac_msg_padder against a byte-stream padding model.
module tb_hmac_msg_padder;
`ifdef HMAC_HW_PAD_EN
    localparam bit HW_PAD = 1'b1;
`else
    localparam bit HW_PAD = 1'b0;
`endif

    logic          clk, reset_n, zeroize, start, msg_valid, msg_last, core_ready;
    logic [31:0]   msg_data;
    logic [2:0]    msg_bytes;
    logic          msg_ready, core_init, core_next, busy, err;
    logic [1023:0] core_block;

    logic [1023:0] exp_q[$];
    logic [31:0]   words[$];
    int            last_nb;
    int            n_checks = 0;
    int            n_errors = 0;

    hmac_msg_padder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .zeroize    (zeroize),
        .start      (start),
        .msg_valid  (msg_valid),
        .msg_data   (msg_data),
        .msg_last   (msg_last),
        .msg_bytes  (msg_bytes),
        .msg_ready  (msg_ready),
        .core_init  (core_init),
        .core_next  (core_next),
        .core_block (core_block),
        .core_ready (core_ready),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_block(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        logic [1023:0] g, e;
        for (int j = 0; j < 32; j++) begin
            g = got << (32 * j);
            e = exp << (32 * j);
            check($sformatf("%s.w%0d", tag, j), 64'(g[1023:992]), 64'(e[1023:992]));
        end
    endtask

    // Model: flatten the message to bytes, append standard SHA-512 padding, cut into blocks.
    function automatic void build_expected();
        logic [7:0]    bytes[$];
        logic [31:0]   w;
        logic [127:0]  len;
        logic [1023:0] blk;
        int            n, keep;
        exp_q.delete();
        for (int i = 0; i < words.size(); i++) begin
            keep = 4;
            if (HW_PAD && i == words.size() - 1) keep = (last_nb > 4) ? 4 : last_nb;
            for (int b = 0; b < keep; b++) begin
                w = words[i] << (8 * b);
                bytes.push_back(w[31:24]);
            end
        end
        if (HW_PAD) begin
            n = bytes.size();
            bytes.push_back(8'h80);
            while (bytes.size() % 128 != 112) bytes.push_back(8'h00);
            len = 128'(n) * 128'd8 + 128'd1024;
            for (int b = 0; b < 16; b++) begin
                logic [127:0] s;
                s = len << (8 * b);
                bytes.push_back(s[127:120]);
            end
        end else begin
            while (bytes.size() % 128 != 0) bytes.push_back(8'h00);
        end
        for (int k = 0; k < bytes.size() / 128; k++) begin
            blk = '0;
            for (int j = 0; j < 128; j++) blk = {blk[1015:0], bytes[128 * k + j]};
            exp_q.push_back(blk);
        end
    endfunction

    task automatic drive_msg();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            bit is_last = (i == words.size() - 1);
            bit hs = 1'b0;
            int t = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            msg_valid = 1'b1;
            msg_data  = words[i];
            msg_last  = is_last;
            msg_bytes = is_last ? 3'(last_nb) : 3'($urandom_range(0, 7));
            start     = (i == 1);
            while (!hs && t < 3000) begin
                @(negedge clk);
                hs = msg_ready;
                @(posedge clk); #1;
                t++;
            end
            msg_valid = 1'b0;
            msg_last  = 1'b0;
            start     = 1'b0;
            if (!hs) begin
                check("msg_accept_timeout", 64'(0), 64'(1));
                return;
            end
            if (!is_last && i % 32 == 31) begin
                @(negedge clk);
                check("ready_drop", 64'(msg_ready), 64'(0));
            end
        end
    endtask

    task automatic monitor(input int hold);
        for (int k = 0; k < exp_q.size(); k++) begin
            bit seen = 1'b0;
            int t = 0;
            int h = (k == 0) ? hold : 0;
            while (!seen && t < 3000) begin
                @(posedge clk); #1;
                if (t < h) core_ready = 1'b0;
                else if (h > 0 && t == h) core_ready = 1'b1;
                else core_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                seen = core_init | core_next;
                if (t < h) check("hold_no_pulse", 64'(seen), 64'(0));
                if (h > 0 && t == h - 1) check_block("hold_blk", core_block, exp_q[k]);
                if (h > 0 && t == h) check("hold_rise_pulse", 64'(seen), 64'(1));
                t++;
            end
            if (!seen) begin
                check("pulse_timeout", 64'(0), 64'(1));
                return;
            end
            check($sformatf("pulse_kind%0d", k), 64'({core_init, core_next}), (k == 0) ? 64'(2) : 64'(1));
            check_block($sformatf("blk%0d", k), core_block, exp_q[k]);
            @(posedge clk); #1;
            core_ready = 1'b1;
            @(negedge clk);
            check("skip_no_pulse", 64'(core_init | core_next), 64'(0));
            check("skip_busy", 64'(busy), 64'(1));
            check_block("skip_stable", core_block, exp_q[k]);
            t = 0;
            do begin
                @(posedge clk); #1;
                core_ready = (t >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                check("wait_no_pulse", 64'(core_init | core_next), 64'(0));
                check_block("wait_stable", core_block, exp_q[k]);
                t++;
            end while (!core_ready);
            @(posedge clk); #1;
            core_ready = 1'b0;
            @(negedge clk);
            check("post_busy", 64'(busy), (k < exp_q.size() - 1) ? 64'(1) : 64'(0));
        end
    endtask

    task automatic run_msg(input int hold);
        build_expected();
        fork
            drive_msg();
            monitor(hold);
        join
        check("err_clear", 64'(err), 64'(0));
    endtask

    task automatic load_random(input int n_words, input int nb);
        words.delete();
        for (int i = 0; i < n_words; i++) words.push_back($urandom());
        last_nb = nb;
    endtask

    initial begin
        reset_n = 1'b0; zeroize = 1'b0; start = 1'b0; msg_valid = 1'b0;
        msg_last = 1'b0; msg_bytes = 3'd0; msg_data = 32'd0; core_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(msg_ready), 64'(0));
        check("rst_pulses", 64'({core_init, core_next}), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_block", 64'(core_block != '0), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // "abc", with the core held not-ready for a while in ISSUE.
        words.delete();
        words.push_back(32'h6162_6300);
        last_nb = 3;
        run_msg(40);

        load_random(28, 3);  run_msg(0);   // 111 bytes
        load_random(28, 4);  run_msg(0);   // 112 bytes
        load_random(32, 4);  run_msg(0);   // 128 bytes
        load_random(33, 0);  run_msg(0);   // 128 bytes plus empty last word

        // Zeroize while the first block of a 112-byte message sits in WAIT.
        load_random(28, 4);
        build_expected();
        fork
            drive_msg();
            begin
                bit seen = 1'b0;
                int t = 0;
                while (!seen && t < 3000) begin
                    @(posedge clk); #1;
                    core_ready = 1'b1;
                    @(negedge clk);
                    seen = core_init | core_next;
                    t++;
                end
                check("zz_pulse_seen", 64'(seen), 64'(1));
                @(posedge clk); #1;
                zeroize = 1'b1;
                @(posedge clk); #1;
                zeroize = 1'b0;
                @(negedge clk);
                check("zz_busy", 64'(busy), 64'(0));
                check("zz_ready", 64'(msg_ready), 64'(0));
                check("zz_block", 64'(core_block != '0), 64'(0));
                repeat (20) begin
                    @(negedge clk);
                    check("zz_no_pulse", 64'(core_init | core_next), 64'(0));
                end
                core_ready = 1'b0;
            end
        join
        load_random(1, 2);   run_msg(0);   // start works again after zeroize

        for (int r = 0; r < 12; r++) begin
            load_random($urandom_range(1, 70), $urandom_range(0, 7));
            run_msg(0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
